// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB (+TRAP).
// Optional illegal-opcode trap: define MCU_ILLEGAL_TRAP_EN.
module multicycle_control_unit #(
  parameter int OP_W    = 2,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               rs_cont,
  output logic               al1_cont,
  output logic [1:0]         al2_cont,
  output logic               j_flag,
  output logic               pc_cont,
  output logic               reg_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               mem_req,
  output logic [2:0]         state,
  output logic               busy
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         cls_q, cls_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic               rs_q, rs_d;
  logic               al1_q, al1_d;
  logic [1:0]         al2_q, al2_d;
  logic               j_q, j_d;
  logic               pcc_q, pcc_d;
  logic               rw_q, rw_d;
  logic               pcw_q, pcw_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               fetch_fire;
  logic               in_op;

`ifdef MCU_ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal = |(opcode >> 2);
`else
  logic unused_hi;
  assign unused_hi = |(opcode >> 2);
`endif

  // Fetch completes only once the request has actually been issued.
  assign fetch_fire = (state_q == FETCH) && req_q && mem_ready;

  always_comb begin
    state_d = FETCH;
    cls_d   = cls_q;
    case (state_q)
      FETCH:  state_d = fetch_fire ? DECODE : FETCH;
      DECODE: begin
        cls_d   = opcode[1:0];
`ifdef MCU_ILLEGAL_TRAP_EN
        state_d = illegal ? TRAP : EXEC;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        case (cls_q)
          2'b10:   state_d = MEM;
          2'b11:   state_d = FETCH;
          default: state_d = WB;
        endcase
      end
      MEM:     state_d = mem_ready ? WB : MEM;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are registered from the state being entered.
  always_comb begin
    in_op    = (state_d == EXEC) || (state_d == MEM) ||
               (state_d == WB);
    alu_op_d = '0;
    rs_d     = 1'b0;
    al1_d    = 1'b0;
    al2_d    = 2'b00;
    if (in_op) begin
      alu_op_d = ALUOP_W'(cls_d);
      rs_d     = |cls_d;
      al1_d    = &cls_d;
      al2_d    = cls_d;
    end
    j_d    = (state_d == EXEC) && (cls_d == 2'b11);
    pcc_d  = j_d;
    pcw_d  = j_d;
    rw_d   = (state_d == WB);
    req_d  = (state_d == FETCH) || (state_d == MEM);
    busy_d = (state_d != FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      cls_q    <= 2'b00;
      alu_op_q <= '0;
      rs_q     <= 1'b0;
      al1_q    <= 1'b0;
      al2_q    <= 2'b00;
      j_q      <= 1'b0;
      pcc_q    <= 1'b0;
      rw_q     <= 1'b0;
      pcw_q    <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      alu_op_q <= alu_op_d;
      rs_q     <= rs_d;
      al1_q    <= al1_d;
      al2_q    <= al2_d;
      j_q      <= j_d;
      pcc_q    <= pcc_d;
      rw_q     <= rw_d;
      pcw_q    <= pcw_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign rs_cont   = rs_q;
  assign al1_cont  = al1_q;
  assign al2_cont  = al2_q;
  assign j_flag    = j_q;
  assign pc_cont   = pcc_q;
  assign reg_write = rw_q;
  assign ir_write  = fetch_fire;
  assign pc_write  = pcw_q | fetch_fire;
  assign mem_req   = req_q;
  assign state     = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed cases plus
// randomized traffic against an instruction-plan model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic       rs_cont, al1_cont, j_flag, pc_cont;
  logic [1:0] al2_cont;
  logic       reg_write, ir_write, pc_write, mem_req, busy;
  logic [2:0] state;

`ifdef MCU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  multicycle_control_unit #(.OP_W(4), .ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready), .alu_op(alu_op),
    .rs_cont(rs_cont), .al1_cont(al1_cont),
    .al2_cont(al2_cont), .j_flag(j_flag),
    .pc_cont(pc_cont), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write),
    .mem_req(mem_req), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // Model: each instruction is a plan of states after DECODE.
  int m_state = 0;
  int m_cls = 0;
  bit m_started = 0;
  int plan[$];

  task automatic model_step();
    case (m_state)
      0: begin
        if (m_started && mem_ready) m_state = 1;
        m_started = 1;
      end
      1: begin
        m_cls = int'(opcode) % 4;
        if (TRAP_EN && (int'(opcode) / 4) != 0) begin
          m_state = 5;
        end else begin
          plan.delete();
          case (m_cls)
            2:       plan = '{2, 3, 4};
            3:       plan = '{2};
            default: plan = '{2, 4};
          endcase
          m_state = plan.pop_front();
        end
      end
      3: if (mem_ready) m_state = plan.pop_front();
      2, 4: m_state = (plan.size() != 0) ?
                      plan.pop_front() : 0;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state   = 0;
      m_cls     = 0;
      m_started = 0;
      plan.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    bit op, jmp, ff;
    #1;
    op  = (m_state >= 2 && m_state <= 4);
    jmp = (m_state == 2) && (m_cls == 3);
    ff  = (m_state == 0) && m_started && mem_ready;
    chk("state", state, m_state);
    chk("alu_op", alu_op, op ? m_cls : 0);
    chk("rs_cont", rs_cont, op && m_cls != 0);
    chk("al1_cont", al1_cont, op && m_cls == 3);
    chk("al2_cont", al2_cont, op ? m_cls : 0);
    chk("j_flag", j_flag, jmp);
    chk("pc_cont", pc_cont, jmp);
    chk("pc_write", pc_write, jmp || ff);
    chk("ir_write", ir_write, ff);
    chk("reg_write", reg_write, m_state == 4);
    chk("mem_req", mem_req,
        (m_state == 0 && m_started) || m_state == 3);
    chk("busy", busy, m_state != 0);
  end

  task automatic step(input bit rdy, input logic [3:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type
    step(1, 0); chk("r_fetch", state, 0);
    chk("r_ir", ir_write, 1);
    step(1, 0); chk("r_dec", state, 1);
    chk("r_dec_rw", reg_write, 0);
    step(1, 0); chk("r_exec", state, 2);
    chk("r_alu", alu_op, 0);
    step(1, 0); chk("r_wb", state, 4);
    chk("r_rw", reg_write, 1);
    step(1, 2); chk("r_done", state, 0);
    chk("r_done_rw", reg_write, 0);

    // load with 3 wait cycles in MEM
    step(1, 2); chk("ld_dec", state, 1);
    step(1, 2); chk("ld_exec", state, 2);
    chk("ld_alu", alu_op, 3'd2);
    chk("ld_al2", al2_cont, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step(0, 2); chk("ld_mem", state, 3);
      chk("ld_req", mem_req, 1);
      chk("ld_rw", reg_write, 0);
    end
    step(1, 2); chk("ld_mem4", state, 3);
    step(1, 3); chk("ld_wb", state, 4);
    chk("ld_rw_wb", reg_write, 1);

    // jump
    step(1, 3); chk("j_fetch", state, 0);
    step(1, 3); chk("j_dec", state, 1);
    step(0, 3); chk("j_exec", state, 2);
    chk("j_flag", j_flag, 1);
    chk("j_pcc", pc_cont, 1);
    chk("j_pcw", pc_write, 1);
    chk("j_rw", reg_write, 0);

    // fetch stall of 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(0, 0); chk("st_state", state, 0);
      chk("st_req", mem_req, 1);
      chk("st_ir", ir_write, 0);
      chk("st_pcw", pc_write, 0);
    end
    step(1, 0); chk("st_ir_go", ir_write, 1);
    chk("st_pcw_go", pc_write, 1);
    step(1, 0); chk("st_dec", state, 1);
    step(1, 0); step(1, 0); step(1, 2);
    chk("st_next", state, 0);

    // reset in the middle of MEM
    step(1, 2); step(1, 2);
    step(1, 2); chk("rm_mem", state, 3);
    rst_n = 1'b0;
    #1;
    chk("rm_state", state, 0);
    chk("rm_req", mem_req, 0);
    chk("rm_alu", alu_op, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rs", rs_cont, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0); chk("rm_fresh", state, 0);
    chk("rm_fresh_rw", reg_write, 0);

    // illegal opcode 4'b0100
    step(1, 4); chk("il_dec", state, 1);
    if (TRAP_EN) begin
      for (int i = 0; i < 3; i++) begin
        step(1, 4); chk("il_trap", state, 5);
        chk("il_busy", busy, 1);
        chk("il_req", mem_req, 0);
      end
    end else begin
      step(1, 4); chk("il_exec", state, 2);
      chk("il_alu", alu_op, 0);
      step(1, 4); chk("il_wb", state, 4);
      step(1, 4); chk("il_done", state, 0);
    end

    // randomized traffic
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0)
        opcode = 4'($urandom);
      else
        opcode = 4'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 49) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OP_W, default 2: opcode width; values ≥2; only the low 2 bits select the class, and the upper bits are checked for legality.
REQ-002 Parameter ALUOP_W, default 2: width of alu_op; the class code is zero-extended into it.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  OP_W  instruction class field; sampled only in DECODE.
REQ-006 mem_ready  input  1  memory handshake response; read-data valid or fetch complete.
REQ-007 alu_op  output  ALUOP_W  ALU operation select.
REQ-008 rs_cont, al1_cont  output  1 each  operand-source selects.
REQ-009 al2_cont  output  2  ALU operand-2 select.
REQ-010 j_flag, pc_cont  output  1 each  jump-taken flag and PC-source select.
REQ-011 reg_write, ir_write, pc_write  output  1 each  register-file, IR and PC write strobes.
REQ-012 mem_req  output  1  memory request; held until mem_ready.
REQ-013 state  output  3  current FSM state code, for debug.
REQ-014 busy  output  1  high in every state except FETCH.

Function
REQ-015 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 are unreachable and shall go to FETCH.
REQ-016 FETCH: mem_req=1; on mem_ready=1, pulse ir_write and pc_write (PC+4, pc_cont=0) in the same cycle, then go to DECODE; with mem_ready=0, stay in FETCH.
REQ-017 DECODE: register opcode into an internal class register; next state is EXEC; no strobes asserted.
REQ-018 EXEC class 00, R-type: rs_cont=0, al1_cont=0, al2_cont=00; next state WB.
REQ-019 EXEC class 01, I-type: rs_cont=1, al1_cont=0, al2_cont=01; next state WB.
REQ-020 EXEC class 10, load: rs_cont=1, al1_cont=0, al2_cont=10 (address calculation); next state MEM.
REQ-021 EXEC class 11, jump: rs_cont=1, al1_cont=1, al2_cont=11, j_flag=1, pc_cont=1, pc_write=1 for one cycle; reg_write=0; next state FETCH.
REQ-022 alu_op equals the registered class (zero-extended) in EXEC, MEM and WB; it is 0 elsewhere.
REQ-023 MEM: mem_req=1 until mem_ready=1, then go to WB; there is no timeout.
REQ-024 WB: reg_write=1 for exactly one cycle, with the operand selects held from EXEC; next state FETCH.
REQ-025 Latency in cycles, assuming mem_ready is immediate: R-type and I-type 4, load 5, jump 3; each mem_ready wait cycle adds one.
REQ-026 Outputs are Moore-registered from state and class, except ir_write and pc_write in FETCH, which are gated by mem_ready.
REQ-027 mem_ready outside FETCH and MEM shall be ignored.

Reset
REQ-028 rst_n=0 forces, asynchronously, state=FETCH, class=0, and every strobe, select and alu_op to 0.
REQ-029 Reset during MEM or FETCH shall abandon the transaction: mem_req drops immediately.
REQ-030 After rst_n rises, the first edge shall begin a fresh FETCH.

Configuration
REQ-031 Macro MCU_ILLEGAL_TRAP_EN.
- Defined: in DECODE, any nonzero opcode bits above bit 1 shall go to TRAP. TRAP holds all strobes at 0 and busy=1 until reset.
- Undefined: the upper bits are ignored, TRAP is unreachable, and decoding uses the low 2 bits only.

Verification
REQ-032 R-type: rst_n pulse, opcode=00, mem_ready=1 constant -> state sequence 0,1,2,4,0; exactly one reg_write pulse, in WB; alu_op=00 in EXEC.
REQ-033 Load with wait: opcode=10, mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles with mem_req held; reg_write appears only after mem_ready.
REQ-034 Jump: opcode=11 -> EXEC has j_flag=1, pc_cont=1, pc_write=1 for one cycle; no reg_write pulse; 3-cycle instruction.
REQ-035 Fetch stall: mem_ready=0 for 5 cycles in FETCH -> state stays 0 with mem_req=1; ir_write and pc_write pulse only on the ready cycle.
REQ-036 Reset mid-MEM: drop rst_n while in MEM -> all outputs 0 immediately, state=0; no reg_write afterward.
REQ-037 Illegal opcode, OP_W=4, opcode=4'b0100: with MCU_ILLEGAL_TRAP_EN -> state=5 and held until reset; without it -> executes as R-type.
